// File: rtl/sobel_frame_scheduler_if.sv
// Signal bundle between sobel_frame_scheduler (master side) and its frame RAMs,
// Sobel engine and frame controller (slave side).
interface sobel_frame_scheduler_if #(
  parameter int ADDR_W  = 18,
  parameter int EADDR_W = 18
);
  logic               frame_start;
  logic               busy;
  logic               frame_done;
  logic               src_rd;
  logic [ADDR_W-1:0]  src_addr;
  logic [7:0]         src_data;
  logic               eng_start;
  logic               eng_done;
  logic [7:0]         eng_z;
  logic [7:0]         win_p1, win_p2, win_p3, win_p4;
  logic [7:0]         win_p6, win_p7, win_p8, win_p9;
  logic               edge_we;
  logic [EADDR_W-1:0] edge_addr;
  logic [7:0]         edge_data;
  logic               err;

  modport master (
    input  frame_start, src_data, eng_done, eng_z,
    output busy, frame_done, src_rd, src_addr, eng_start,
           win_p1, win_p2, win_p3, win_p4, win_p6, win_p7, win_p8, win_p9,
           edge_we, edge_addr, edge_data, err
  );

  modport slave (
    output frame_start, src_data, eng_done, eng_z,
    input  busy, frame_done, src_rd, src_addr, eng_start,
           win_p1, win_p2, win_p3, win_p4, win_p6, win_p7, win_p8, win_p9,
           edge_we, edge_addr, edge_data, err
  );
endinterface

// File: rtl/sobel_frame_scheduler.sv
// Walks a ROWS x COLS frame through the 3x3 Sobel engine, one interior pixel per job.
// Optional engine watchdog: define SOBEL_SCHED_TIMEOUT_EN.
module sobel_frame_scheduler #(
  parameter int ROWS        = 436,
  parameter int COLS        = 576,
  parameter int ADDR_W      = 18,
  parameter int EADDR_W     = 18,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  sobel_frame_scheduler_if.master sched_if
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_WRITE, S_NEXT
  } state_e;

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(ROWS - 2);
  localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(COLS - 2);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  if (ROWS < 3 || COLS < 3 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("sobel_frame_scheduler: ROWS and COLS must be >= 3, TIMEOUT_CYC >= 1");
  end

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  i_q, j_q;
  logic               full_q;
  logic [3:0]         iss_cnt_q;
  logic [1:0]         iss_rr_q, iss_wc_q;
  logic               cap_vld_q;
  logic [1:0]         cap_rr_q, cap_wc_q;
  logic               done_prev_q;
  logic [7:0]         win_q [3][3];
  logic [7:0]         edge_data_q;
  logic [EADDR_W-1:0] eaddr_q;

  logic [3:0]         n_reads;
  logic               issue, done_rise, timeout, more_i, more_j, frame_done;
  logic [ADDR_W-1:0]  rd_row, rd_col;

  // Row-start fetches three columns (9 reads); a slide fetches only the new right column.
  assign n_reads   = full_q ? 4'd9 : 4'd3;
  assign issue     = (state_q == S_FETCH) && (iss_cnt_q != n_reads);
  assign done_rise = sched_if.eng_done && !done_prev_q;
  assign more_i    = i_q < LAST_I;
  assign more_j    = j_q < LAST_J;
  assign rd_row    = i_q - ONE + ADDR_W'(iss_rr_q);
  assign rd_col    = j_q - ONE + ADDR_W'(iss_wc_q);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE:   if (sched_if.frame_start) state_d = S_FETCH;
      S_FETCH:  if (iss_cnt_q == n_reads) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (done_rise || timeout) state_d = S_WRITE;
      S_WRITE:  state_d = S_NEXT;
      S_NEXT: begin
        if (more_j || more_i) begin
          state_d = S_FETCH;
        end else begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_q         <= ONE;
      j_q         <= ONE;
      full_q      <= 1'b1;
      iss_cnt_q   <= '0;
      iss_rr_q    <= '0;
      iss_wc_q    <= '0;
      cap_vld_q   <= 1'b0;
      cap_rr_q    <= '0;
      cap_wc_q    <= '0;
      done_prev_q <= 1'b0;
      // NOTE: the window is nine flops driving outputs, not a RAM, so it is reset like any register.
      win_q       <= '{default: '0};
      edge_data_q <= '0;
      eaddr_q     <= '0;
    end else begin
      done_prev_q <= sched_if.eng_done;
      cap_vld_q   <= issue;
      cap_rr_q    <= iss_rr_q;
      cap_wc_q    <= iss_wc_q;
      if (cap_vld_q) win_q[cap_rr_q][cap_wc_q] <= sched_if.src_data;

      if (issue) begin
        iss_cnt_q <= iss_cnt_q + 4'd1;
        if (iss_rr_q == 2'd2) begin
          iss_rr_q <= 2'd0;
          iss_wc_q <= iss_wc_q + 2'd1;
        end else begin
          iss_rr_q <= iss_rr_q + 2'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (sched_if.frame_start) begin
            i_q       <= ONE;
            j_q       <= ONE;
            eaddr_q   <= '0;
            full_q    <= 1'b1;
            iss_cnt_q <= '0;
            iss_rr_q  <= '0;
            iss_wc_q  <= '0;
          end
        end
        S_WAIT: begin
          if (done_rise)    edge_data_q <= sched_if.eng_z;
          else if (timeout) edge_data_q <= '0;
        end
        S_WRITE: eaddr_q <= eaddr_q + EADDR_W'(1);
        S_NEXT: begin
          if (more_j) begin
            j_q <= j_q + ONE;
            for (int r = 0; r < 3; r++) begin
              win_q[r][0] <= win_q[r][1];
              win_q[r][1] <= win_q[r][2];
            end
            full_q    <= 1'b0;
            iss_cnt_q <= '0;
            iss_rr_q  <= '0;
            iss_wc_q  <= 2'd2;
          end else if (more_i) begin
            i_q       <= i_q + ONE;
            j_q       <= ONE;
            full_q    <= 1'b1;
            iss_cnt_q <= '0;
            iss_rr_q  <= '0;
            iss_wc_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SOBEL_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  // Counts cycles spent in WAIT; a hung engine yields a 0x00 result and a sticky error.
  assign timeout = (state_q == S_WAIT) && !done_rise && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == S_WAIT) to_cnt_q <= to_cnt_q + TO_W'(1);
      else                   to_cnt_q <= '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign sched_if.err = err_q;
`else
  assign timeout      = 1'b0;
  assign sched_if.err = 1'b0;
`endif

  assign sched_if.busy       = (state_q != S_IDLE);
  assign sched_if.frame_done = frame_done;
  assign sched_if.src_rd     = issue;
  assign sched_if.src_addr   = issue ? (rd_row * COLS_A + rd_col) : '0;
  assign sched_if.eng_start  = (state_q != S_WAIT);
  assign sched_if.edge_we    = (state_q == S_WRITE);
  assign sched_if.edge_addr  = eaddr_q;
  assign sched_if.edge_data  = edge_data_q;
  assign sched_if.win_p1     = win_q[0][0];
  assign sched_if.win_p2     = win_q[0][1];
  assign sched_if.win_p3     = win_q[0][2];
  assign sched_if.win_p4     = win_q[1][0];
  assign sched_if.win_p6     = win_q[1][2];
  assign sched_if.win_p7     = win_q[2][0];
  assign sched_if.win_p8     = win_q[2][1];
  assign sched_if.win_p9     = win_q[2][2];
endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed bench for sobel_frame_scheduler on 5x5 and 3x3 ramp frames (pixel = address)
// with a behavioural engine: done 10 cycles after launch, z = p1 + p9.
`timescale 1ns/1ps
module tb_sobel_frame_scheduler;
  localparam int BUDGET = 3000;

  logic clk  = 1'b0;
  logic rst5 = 1'b1;
  logic rst3 = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_frame_scheduler_if #(.ADDR_W(5), .EADDR_W(4)) if5 ();
  sobel_frame_scheduler_if #(.ADDR_W(4), .EADDR_W(1)) if3 ();

  sobel_frame_scheduler #(.ROWS(5), .COLS(5), .ADDR_W(5), .EADDR_W(4), .TIMEOUT_CYC(16))
    u_dut5 (.clk(clk), .reset(rst5), .sched_if(if5));
  sobel_frame_scheduler #(.ROWS(3), .COLS(3), .ADDR_W(4), .EADDR_W(1), .TIMEOUT_CYC(16))
    u_dut3 (.clk(clk), .reset(rst3), .sched_if(if3));

  // Source RAMs: ramp image, so each pixel equals its own row-major address.
  always @(posedge clk) begin
    if (if5.src_rd) if5.src_data <= 8'(if5.src_addr);
    if (if3.src_rd) if3.src_data <= 8'(if3.src_addr);
  end

  // Engine model for the 5x5 instance; hold5 keeps done high between jobs, skip5 never answers.
  logic       st5_q = 1'b1;
  int         cnt5  = 0;
  int         job5  = 0;
  int         skip5 = -1;
  bit         hold5 = 1'b0;
  logic [7:0] wlog5 [16][8];
  always @(posedge clk) begin
    if (rst5) begin
      st5_q        <= 1'b1;
      cnt5         <= 0;
      if5.eng_done <= 1'b0;
      if5.eng_z    <= 8'h00;
    end else begin
      st5_q <= if5.eng_start;
      if (st5_q && !if5.eng_start) begin
        job5         <= job5 + 1;
        if5.eng_done <= 1'b0;
        if5.eng_z    <= if5.win_p1 + if5.win_p9;
        cnt5         <= (job5 + 1 == skip5) ? 0 : 10;
        if (job5 < 9)
          wlog5[job5[3:0]] <= '{if5.win_p1, if5.win_p2, if5.win_p3, if5.win_p4,
                                if5.win_p6, if5.win_p7, if5.win_p8, if5.win_p9};
      end else if (if5.eng_start && !hold5) begin
        cnt5         <= 0;
        if5.eng_done <= 1'b0;
      end else if (cnt5 == 1) begin
        cnt5         <= 0;
        if5.eng_done <= 1'b1;
      end else if (cnt5 > 1) begin
        cnt5 <= cnt5 - 1;
      end
    end
  end

  logic st3_q = 1'b1;
  int   cnt3  = 0;
  always @(posedge clk) begin
    if (rst3) begin
      st3_q        <= 1'b1;
      cnt3         <= 0;
      if3.eng_done <= 1'b0;
      if3.eng_z    <= 8'h00;
    end else begin
      st3_q <= if3.eng_start;
      if (st3_q && !if3.eng_start) begin
        if3.eng_done <= 1'b0;
        if3.eng_z    <= if3.win_p1 + if3.win_p9;
        cnt3         <= 10;
      end else if (if3.eng_start) begin
        cnt3         <= 0;
        if3.eng_done <= 1'b0;
      end else if (cnt3 == 1) begin
        cnt3         <= 0;
        if3.eng_done <= 1'b1;
      end else if (cnt3 > 1) begin
        cnt3 <= cnt3 - 1;
      end
    end
  end

  // Write/read/frame_done monitors.
  int         wr5 = 0, rd5 = 0, fd5 = 0;
  logic [3:0] wa5 [64];
  logic [7:0] wd5 [64];
  int         wr3 = 0, rd3 = 0, fd3 = 0, lastwe3 = 0, fdcyc3 = 0;
  logic [0:0] wa3_last = '0;
  logic [7:0] wd3_last = '0;
  always @(posedge clk) begin
    if (if5.edge_we) begin
      if (wr5 < 64) begin
        wa5[wr5[5:0]] <= if5.edge_addr;
        wd5[wr5[5:0]] <= if5.edge_data;
      end
      wr5 <= wr5 + 1;
    end
    if (if5.src_rd)     rd5 <= rd5 + 1;
    if (if5.frame_done) fd5 <= fd5 + 1;
    if (if3.edge_we) begin
      wa3_last <= if3.edge_addr;
      wd3_last <= if3.edge_data;
      lastwe3  <= cyc;
      wr3      <= wr3 + 1;
    end
    if (if3.src_rd) rd3 <= rd3 + 1;
    if (if3.frame_done) begin
      fd3    <= fd3 + 1;
      fdcyc3 <= cyc;
    end
  end

  // Expected result of window k in a 5x5 ramp: p1 + p9 = (5(i-1)+j-1) + (5(i+1)+j+1).
  function automatic logic [7:0] exp_z5(input int k);
    return 8'(10 * (k / 3 + 1) + 2 * (k % 3 + 1));
  endfunction

  task automatic pulse5();
    @(negedge clk) if5.frame_start = 1'b1;
    @(negedge clk) if5.frame_start = 1'b0;
  endtask

  task automatic wait_fd5(input int base, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < BUDGET && !ok; k++) begin
      @(negedge clk);
      ok = (fd5 > base);
    end
  endtask

  task automatic test_reset();
    int    act  [12];
    int    expv [12];
    string nm   [12];
    nm   = '{"busy", "frame_done", "src_rd", "edge_we", "err", "eng_start", "src_addr",
             "edge_addr", "edge_data", "win_p1", "win_p9", "busy3"};
    expv = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    act  = '{int'(if5.busy), int'(if5.frame_done), int'(if5.src_rd), int'(if5.edge_we),
             int'(if5.err), int'(if5.eng_start), int'(if5.src_addr), int'(if5.edge_addr),
             int'(if5.edge_data), int'(if5.win_p1), int'(if5.win_p9), int'(if3.busy)};
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (act[k] !== expv[k]) begin
        n_fail++;
        $display("FAIL reset_%s: got %0d, expected %0d", nm[k], act[k], expv[k]);
      end
    end
  endtask

  task automatic test_frame5();
    int bw = wr5, br = rd5, bf = fd5;
    bit ok;
    int ew [8];
    pulse5();
    n_checks++;
    if (if5.busy !== 1'b1) begin
      n_fail++; $display("FAIL frame5_busy_high: got %0b, expected 1", if5.busy);
    end
    wait_fd5(bf, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL frame5_timeout: frame_done not seen, expected within %0d cycles", BUDGET); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr5 - bw !== 9) begin n_fail++; $display("FAIL frame5_writes: got %0d, expected 9", wr5 - bw); end
    n_checks++;
    if (rd5 - br !== 45) begin n_fail++; $display("FAIL frame5_reads: got %0d, expected 45", rd5 - br); end
    n_checks++;
    if (fd5 - bf !== 1) begin n_fail++; $display("FAIL frame5_done_count: got %0d, expected 1", fd5 - bf); end
    n_checks++;
    if (if5.busy !== 1'b0 || if5.err !== 1'b0) begin
      n_fail++; $display("FAIL frame5_idle: busy=%0b err=%0b, expected 0 0", if5.busy, if5.err);
    end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (wa5[bw + k] !== 4'(k) || wd5[bw + k] !== exp_z5(k)) begin
        n_fail++;
        $display("FAIL frame5_write%0d: addr=%0d data=0x%02h, expected addr=%0d data=0x%02h",
                 k, wa5[bw + k], wd5[bw + k], k, exp_z5(k));
      end
    end
    // Windows 0, 4, 8: neighbours of centre c = 5i+j in the ramp.
    for (int w = 0; w < 9; w += 4) begin
      int c = 5 * (w / 3 + 1) + (w % 3 + 1);
      ew = '{c - 6, c - 5, c - 4, c - 1, c + 1, c + 4, c + 5, c + 6};
      for (int p = 0; p < 8; p++) begin
        n_checks++;
        if (wlog5[w][p] !== 8'(ew[p])) begin
          n_fail++;
          $display("FAIL frame5_window%0d_px%0d: got %0d, expected %0d", w, p, wlog5[w][p], ew[p]);
        end
      end
    end
  endtask

  task automatic test_frame3();
    bit ok = 1'b0;
    @(negedge clk) if3.frame_start = 1'b1;
    @(negedge clk) if3.frame_start = 1'b0;
    for (int k = 0; k < BUDGET && !ok; k++) begin
      @(negedge clk);
      ok = (fd3 > 0);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || wr3 !== 1 || rd3 !== 9 || fd3 !== 1) begin
      n_fail++;
      $display("FAIL frame3_counts: done=%0b writes=%0d reads=%0d frame_dones=%0d, expected 1 1 9 1",
               ok, wr3, rd3, fd3);
    end
    n_checks++;
    if (wa3_last !== 1'b0 || wd3_last !== 8'h08) begin
      n_fail++; $display("FAIL frame3_write: addr=%0d data=0x%02h, expected addr=0 data=0x08", wa3_last, wd3_last);
    end
    n_checks++;
    if (fdcyc3 - lastwe3 !== 1) begin
      n_fail++; $display("FAIL frame3_done_latency: got %0d cycles, expected 1", fdcyc3 - lastwe3);
    end
    n_checks++;
    if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL frame3_busy_low: got %0b, expected 0", if3.busy); end
  endtask

  task automatic test_start_during_busy();
    int bw = wr5, bf = fd5;
    bit ok;
    pulse5();
    repeat (30) @(negedge clk);
    pulse5();
    repeat (40) @(negedge clk);
    pulse5();
    wait_fd5(bf, ok);
    repeat (100) @(negedge clk);
    n_checks++;
    if (!ok || wr5 - bw !== 9 || fd5 - bf !== 1) begin
      n_fail++;
      $display("FAIL busy_start_ignored: done=%0b writes=%0d frame_dones=%0d, expected 1 9 1", ok, wr5 - bw, fd5 - bf);
    end
    n_checks++;
    if (if5.busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: busy=%0b, expected 0", if5.busy); end
    n_checks++;
    if (wd5[bw + 4] !== exp_z5(4)) begin
      n_fail++; $display("FAIL busy_start_data4: got 0x%02h, expected 0x%02h", wd5[bw + 4], exp_z5(4));
    end
  endtask

  task automatic test_done_held();
    int bw = wr5, bf = fd5;
    bit ok;
    hold5 = 1'b1;
    pulse5();
    wait_fd5(bf, ok);
    repeat (3) @(negedge clk);
    hold5 = 1'b0;
    n_checks++;
    if (!ok || wr5 - bw !== 9 || fd5 - bf !== 1) begin
      n_fail++;
      $display("FAIL held_done_counts: done=%0b writes=%0d frame_dones=%0d, expected 1 9 1", ok, wr5 - bw, fd5 - bf);
    end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (wa5[bw + k] !== 4'(k) || wd5[bw + k] !== exp_z5(k)) begin
        n_fail++;
        $display("FAIL held_done_write%0d: addr=%0d data=0x%02h, expected addr=%0d data=0x%02h",
                 k, wa5[bw + k], wd5[bw + k], k, exp_z5(k));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int bw = wr5, bf = fd5, bj = job5;
    bit ok;
    pulse5();
    for (int k = 0; k < BUDGET && job5 < bj + 4; k++) @(negedge clk);
    n_checks++;
    if (job5 !== bj + 4) begin n_fail++; $display("FAIL midreset_reach_wait4: jobs=%0d, expected %0d", job5 - bj, 4); end
    rst5 = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (if5.eng_start !== 1'b1 || if5.busy !== 1'b0 || if5.edge_we !== 1'b0 || if5.src_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: eng_start=%0b busy=%0b edge_we=%0b src_rd=%0b, expected 1 0 0 0",
               if5.eng_start, if5.busy, if5.edge_we, if5.src_rd);
    end
    @(negedge clk) rst5 = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++;
    if (wr5 - bw !== 3 || fd5 !== bf) begin
      n_fail++; $display("FAIL midreset_no_writes: writes=%0d frame_dones=%0d, expected 3 0", wr5 - bw, fd5 - bf);
    end
    bw = wr5;
    pulse5();
    wait_fd5(bf, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || wr5 - bw !== 9) begin
      n_fail++; $display("FAIL midreset_rerun: done=%0b writes=%0d, expected 1 9", ok, wr5 - bw);
    end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (wa5[bw + k] !== 4'(k) || wd5[bw + k] !== exp_z5(k)) begin
        n_fail++;
        $display("FAIL midreset_write%0d: addr=%0d data=0x%02h, expected addr=%0d data=0x%02h",
                 k, wa5[bw + k], wd5[bw + k], k, exp_z5(k));
      end
    end
  endtask

`ifdef SOBEL_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int         bw = wr5, bf = fd5;
    bit         ok;
    logic [7:0] ed;
    skip5 = job5 + 2;
    pulse5();
    wait_fd5(bf, ok);
    repeat (3) @(negedge clk);
    skip5 = -1;
    n_checks++;
    if (!ok || wr5 - bw !== 9 || fd5 - bf !== 1) begin
      n_fail++;
      $display("FAIL timeout_counts: done=%0b writes=%0d frame_dones=%0d, expected 1 9 1", ok, wr5 - bw, fd5 - bf);
    end
    n_checks++;
    if (if5.err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %0b, expected 1", if5.err); end
    for (int k = 0; k < 9; k++) begin
      ed = (k == 1) ? 8'h00 : exp_z5(k);
      n_checks++;
      if (wa5[bw + k] !== 4'(k) || wd5[bw + k] !== ed) begin
        n_fail++;
        $display("FAIL timeout_write%0d: addr=%0d data=0x%02h, expected addr=%0d data=0x%02h",
                 k, wa5[bw + k], wd5[bw + k], k, ed);
      end
    end
  endtask
`endif

  initial begin
    if5.frame_start = 1'b0;
    if3.frame_start = 1'b0;
    repeat (3) @(negedge clk);
    rst5 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame5();
    test_frame3();
    test_start_during_busy();
    test_done_held();
    test_reset_mid_frame();
`ifdef SOBEL_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
